// File: rtl/alu_seq_defs.sv
// Shared definitions for the nibble ALU sequencer.
// Opcodes, FSM states and control-vector bit positions.
package alu_seq_defs;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOTB  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_INCA  = 4'd5;
  localparam logic [3:0] OP_NEGA  = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;
  localparam logic [3:0] OP_ZERO  = 4'd9;
  localparam logic [3:0] OP_INCB  = 4'd10;

  localparam int CV_CIN  = 0;
  localparam int CV_INVA = 1;
  localparam int CV_ENB  = 2;
  localparam int CV_ENA  = 3;
  localparam int CV_F0   = 4;
  localparam int CV_F1   = 5;
  localparam int CV_W    = 6;

  typedef logic [CV_W-1:0] ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to ALU control decoder.
// Illegal opcodes yield all-zero controls and legal=0.
module alu_op_decode
  import alu_seq_defs::*;
(
  input  logic [3:0] in_op,
  output logic       f1,
  output logic       f0,
  output logic       ena,
  output logic       enb,
  output logic       inva,
  output logic       cin0,
  output logic       is_arith,
  output logic       legal
);

  ctrl_t cv;

  // Table lookup: {F1F0, ENA, ENB, INVA, CIN}
  always_comb begin
    cv    = '0;
    legal = 1'b1;
    case (in_op)
      OP_AND:   cv = 6'b00_1_1_0_0;
      OP_OR:    cv = 6'b01_1_1_0_0;
      OP_NOTB:  cv = 6'b10_1_1_0_0;
      OP_ADD:   cv = 6'b11_1_1_0_0;
      OP_SUB:   cv = 6'b11_1_1_1_1;
      OP_INCA:  cv = 6'b11_1_0_0_1;
      OP_NEGA:  cv = 6'b11_1_0_1_1;
      OP_PASSA: cv = 6'b11_1_0_0_0;
      OP_PASSB: cv = 6'b11_0_1_0_0;
      OP_ZERO:  cv = 6'b11_0_0_0_0;
      OP_INCB:  cv = 6'b11_0_1_0_1;
      default: begin
        cv    = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign f1       = cv[CV_F1];
  assign f0       = cv[CV_F0];
  assign ena      = cv[CV_ENA];
  assign enb      = cv[CV_ENB];
  assign inva     = cv[CV_INVA];
  assign cin0     = cv[CV_CIN];
  assign is_arith = cv[CV_F1] & cv[CV_F0];

endmodule

// File: rtl/bitalu_4.sv
// Combinational 4-bit Mic-1-style ALU slice.
// F=00 AND, 01 OR, 10 NOT B, 11 A+B+CIN.
module bitalu_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       inva,
  input  logic       ena,
  input  logic       enb,
  input  logic       f0,
  input  logic       f1,
  input  logic       cin,
  output logic [3:0] result,
  output logic       cout
);

  logic [3:0] a_e;
  logic [3:0] b_e;
  logic [4:0] sum;

  assign a_e = (ena ? a : 4'h0) ^ {4{inva}};
  assign b_e = enb ? b : 4'h0;
  assign sum = {1'b0, a_e} + {1'b0, b_e} + {4'h0, cin};

  // Function select; carry only meaningful for add
  always_comb begin
    result = 4'h0;
    cout   = 1'b0;
    case ({f1, f0})
      2'b00: result = a_e & b_e;
      2'b01: result = a_e | b_e;
      2'b10: result = ~b_e;
      default: begin
        result = sum[3:0];
        cout   = sum[4];
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Sequences a W-bit op through a 4-bit ALU, one nibble per cycle.
// Carry is chained through carry_q between passes.
module alu_nibble_sequencer
  import alu_seq_defs::*;
#(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_cout,
  output logic         out_zero,
  output logic         out_ovf,
  output logic         out_err,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_inva,
  output logic         alu_ena,
  output logic         alu_enb,
  output logic         alu_f0,
  output logic         alu_f1,
  output logic         alu_cin,
  input  logic [3:0]   alu_result,
  input  logic         alu_cout
);

  localparam logic [1:0] NIB_LAST = 2'(NIBBLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic [1:0]   nib_q, nib_d;
  logic         carry_q, carry_d;
  logic         cout_q, cout_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;

  logic [3:0] dec_op;
  logic d_f1, d_f0, d_ena, d_enb, d_inva;
  logic d_cin0, d_arith, d_legal;
  logic [3:0] nib_a, nib_b;
  logic a_msb, b_msb;

  assign dec_op = (state_q == ST_IDLE) ? in_op : op_q;

  alu_op_decode u_dec (
    .in_op    (dec_op),
    .f1       (d_f1),
    .f0       (d_f0),
    .ena      (d_ena),
    .enb      (d_enb),
    .inva     (d_inva),
    .cin0     (d_cin0),
    .is_arith (d_arith),
    .legal    (d_legal)
  );

  // Select the current operand nibbles
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (nib_q == 2'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  assign a_msb = (d_ena & a_q[W-1]) ^ d_inva;
  assign b_msb = d_enb & b_q[W-1];

  // ALU drive: only active while executing
  always_comb begin
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_inva = 1'b0;
    alu_ena  = 1'b0;
    alu_enb  = 1'b0;
    alu_f0   = 1'b0;
    alu_f1   = 1'b0;
    alu_cin  = 1'b0;
    if (state_q == ST_EXEC) begin
      alu_a    = nib_a;
      alu_b    = nib_b;
      alu_inva = d_inva;
      alu_ena  = d_ena;
      alu_enb  = d_enb;
      alu_f0   = d_f0;
      alu_f1   = d_f1;
      if (nib_q == 2'd0) alu_cin = d_cin0;
      else               alu_cin = d_arith & carry_q;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    nib_d   = nib_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          res_d   = '0;
          nib_d   = 2'd0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = ~d_legal;
          zero_d  = ~d_legal;
          state_d = d_legal ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (nib_q == 2'(i)) res_d[4*i +: 4] = alu_result;
        end
        carry_d = alu_cout;
        nib_d   = nib_q + 2'd1;
        if (nib_q == NIB_LAST) begin
          cout_d  = d_arith & alu_cout;
          ovf_d   = d_arith & (a_msb == b_msb) &
                    (alu_result[3] != b_msb);
          zero_d  = (res_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      nib_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      nib_q   <= nib_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) & ~rst;
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with bitalu_4.
// Expected values are hand-computed per vector.
module tb_alu_nibble_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         out_zero;
  logic         out_ovf;
  logic         out_err;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic alu_inva, alu_ena, alu_enb;
  logic alu_f0, alu_f1, alu_cin, alu_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_err    (out_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_inva   (alu_inva),
    .alu_ena    (alu_ena),
    .alu_enb    (alu_enb),
    .alu_f0     (alu_f0),
    .alu_f1     (alu_f1),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  bitalu_4 u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .inva   (alu_inva),
    .ena    (alu_ena),
    .enb    (alu_enb),
    .f0     (alu_f0),
    .f1     (alu_f1),
    .cin    (alu_cin),
    .result (alu_result),
    .cout   (alu_cout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic alu_any();
    return (|alu_a) | (|alu_b) | alu_inva | alu_ena |
           alu_enb | alu_f0 | alu_f1 | alu_cin;
  endfunction

  // Issue one op; returns latency, 2nd-cycle cin and alu activity
  task automatic issue(input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       output int lat,
                       output logic cin2,
                       output logic any);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    cin2 = 1'b0;
    any  = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) cin2 = alu_cin;
      if (out_valid) break;
      any = any | alu_any();
    end
    if (!out_valid) chk("timeout", 0, 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic [3:0] op,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] e_res,
                     input logic e_c,
                     input logic e_v,
                     input logic e_z,
                     input logic e_err,
                     input int e_lat);
    int lat;
    logic cin2, any;
    issue(op, a, b, lat, cin2, any);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_res"}, out_result, e_res);
    chk({tag, "_c"}, out_cout, e_c);
    chk({tag, "_v"}, out_ovf, e_v);
    chk({tag, "_z"}, out_zero, e_z);
    chk({tag, "_err"}, out_err, e_err);
    chk({tag, "_alu0"}, alu_any(), 0);
    release_out();
  endtask

  initial begin
    int lat;
    logic cin2, any;
    logic [7:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", {out_cout, out_zero, out_ovf, out_err}, 0);
    chk("rst_alu", alu_any(), 0);
    rst = 1'b0;

    issue(4'd3, 8'h7F, 8'h01, lat, cin2, any);
    chk("add_lat", lat, 3);
    chk("add_cin2", cin2, 1);
    chk("add_res", out_result, 8'h80);
    chk("add_c", out_cout, 0);
    chk("add_v", out_ovf, 1);
    chk("add_z", out_zero, 0);
    chk("add_err", out_err, 0);
    release_out();

    run("sub1", 4'd4, 8'h03, 8'h05, 8'h02, 1, 0, 0, 0, 3);
    run("sub2", 4'd4, 8'h05, 8'h03, 8'hFE, 0, 0, 0, 0, 3);
    run("inca", 4'd5, 8'hFF, 8'h00, 8'h00, 1, 0, 1, 0, 3);
    run("nega", 4'd6, 8'h01, 8'h00, 8'hFF, 0, 0, 0, 0, 3);
    run("and",  4'd0, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 3);
    run("notb", 4'd2, 8'h00, 8'h0F, 8'hF0, 0, 0, 0, 0, 3);
    run("passb", 4'd8, 8'h00, 8'hA5, 8'hA5, 0, 0, 0, 0, 3);
    run("or",   4'd1, 8'h50, 8'h0A, 8'h5A, 0, 0, 0, 0, 3);
    run("incb", 4'd10, 8'hFF, 8'h0F, 8'h10, 0, 0, 0, 0, 3);

    issue(4'hF, 8'h12, 8'h34, lat, cin2, any);
    chk("ill_lat", lat, 1);
    chk("ill_res", out_result, 0);
    chk("ill_err", out_err, 1);
    chk("ill_z", out_zero, 1);
    chk("ill_cv", {out_cout, out_ovf}, 0);
    chk("ill_alu", any | alu_any(), 0);
    release_out();

    issue(4'd3, 8'h12, 8'h34, lat, cin2, any);
    chk("hold_res0", out_result, 8'h46);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res", out_result, held);
      chk("hold_rdy", in_ready, 0);
    end
    release_out();

    @(negedge clk);
    in_op    = 4'd3;
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rdy", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_valid", out_valid, 0);
      @(negedge clk);
    end

    run("post_rst", 4'd7, 8'h3C, 8'h00, 8'h3C, 0, 0, 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog");
  end

endmodule
